tribus_arb: RTL and testbench

Round-robin owner arbiter for a shared tristate net driven by N 9-track `invz` tristate-inverter cells, one cell per requester. It produces the per-cell `EN` pins and guarantees that at most one driver is enabled at any time, with a programmable all-off dead time between owners. A bus-float indication is provided so a bus keeper can hold the net during idle and dead time. The block sits beside the tristate drivers in the same standard-cell domain.

---
 rtl/tribus_arb.sv | 98 +++++++++
 tb/tb_tribus_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tribus_arb.sv
// Round-robin owner arbiter for a shared tristate net: one-hot-or-zero driver
// enables, a programmable all-off dead time between owners, and a keeper hint.
module tribus_arb #(
  parameter int N        = 4,
  parameter int DEAD_CYC = 1,
  parameter int HOLD_MAX = 16,
  localparam int NW = (N > 1) ? $clog2(N) : 1,
  localparam int TW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1
) (
  input  logic          CLK,
  input  logic          RN,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic [N-1:0]  EN,
  output logic          FLOAT,
  output logic [NW-1:0] OWNER
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  logic [1:0]    r_state;
  logic [NW-1:0] r_ptr;
  logic [NW-1:0] r_owner;
  logic [N-1:0]  r_gnt;
  logic          r_flt;
  logic [3:0]    r_dcnt;
  logic [TW-1:0] r_ten;

  logic [N-1:0]  w_rot;
  logic          w_hit;
  logic [NW-1:0] w_off;
  logic [NW:0]   w_sum;
  logic [NW-1:0] w_win;
  logic [NW-1:0] w_nptr;
  logic [N-1:0]  w_onehot;
  logic          w_rel;
  logic          w_arb;

  // Rotate requests so bit 0 is the pointer position; the first set bit is the winner offset.
  assign w_rot = N'({REQ, REQ} >> r_ptr);

  always_comb begin
    w_hit = |w_rot;
    w_off = '0;
    for (int j = N - 1; j >= 0; j--)
      if (w_rot[j]) w_off = NW'(j);
  end

  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win    = (w_sum >= (NW+1)'(N)) ? NW'(w_sum - (NW+1)'(N)) : NW'(w_sum);
  assign w_nptr   = (w_win == NW'(N - 1)) ? '0 : w_win + 1'b1;
  assign w_onehot = N'(1) << w_win;

  assign w_rel = !REQ[r_owner] || ((HOLD_MAX != 0) && (r_ten == TW'(HOLD_MAX)));
  // Anything other than OWN or a still-counting DEAD arbitrates, which also recovers an illegal state.
  assign w_arb = (r_state != S_OWN) && !((r_state == S_DEAD) && (r_dcnt != 4'd0));

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_flt   <= 1'b1;
      r_dcnt  <= 4'd0;
      r_ten   <= '0;
    end else if (r_state == S_OWN) begin
      if (w_rel) begin
        r_state <= S_DEAD;
        r_gnt   <= '0;
        r_flt   <= 1'b1;
        r_owner <= '0;
        r_dcnt  <= 4'(DEAD_CYC - 1);
      end else if (r_ten != '1) begin
        r_ten <= r_ten + 1'b1;
      end
    end else if (!w_arb) begin
      r_dcnt <= r_dcnt - 4'd1;
    end else if (w_hit) begin
      r_state <= S_OWN;
      r_gnt   <= w_onehot;
      r_flt   <= 1'b0;
      r_owner <= w_win;
      r_ten   <= TW'(1);
      r_ptr   <= w_nptr;
    end else begin
      r_state <= S_IDLE;
    end
  end

  assign GNT   = r_gnt;
  assign EN    = r_gnt;
  assign FLOAT = r_flt;
  assign OWNER = r_owner;

endmodule

// File: tb/tb_tribus_arb.sv
// Bench for tribus_arb: four instances with different dead/tenure settings share
// REQ/RN; a queue-free behavioural owner model checks every cycle, plus directed cases.
module tb_tribus_arb;
  localparam int N = 4;
  localparam int DV[4] = '{1, 2, 1, 3};
  localparam int HV[4] = '{16, 4, 0, 2};

  logic       CLK;
  logic       RN;
  logic [3:0] REQ;
  logic [3:0] en  [4];
  logic [3:0] gnt [4];
  logic       flt [4];
  logic [1:0] own [4];
  int checks, errors;

  tribus_arb #(.N(4), .DEAD_CYC(1), .HOLD_MAX(16)) u0 (.CLK(CLK), .RN(RN), .REQ(REQ), .GNT(gnt[0]), .EN(en[0]), .FLOAT(flt[0]), .OWNER(own[0]));
  tribus_arb #(.N(4), .DEAD_CYC(2), .HOLD_MAX(4))  u1 (.CLK(CLK), .RN(RN), .REQ(REQ), .GNT(gnt[1]), .EN(en[1]), .FLOAT(flt[1]), .OWNER(own[1]));
  tribus_arb #(.N(4), .DEAD_CYC(1), .HOLD_MAX(0))  u2 (.CLK(CLK), .RN(RN), .REQ(REQ), .GNT(gnt[2]), .EN(en[2]), .FLOAT(flt[2]), .OWNER(own[2]));
  tribus_arb #(.N(4), .DEAD_CYC(3), .HOLD_MAX(2))  u3 (.CLK(CLK), .RN(RN), .REQ(REQ), .GNT(gnt[3]), .EN(en[3]), .FLOAT(flt[3]), .OWNER(own[3]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: owner (-1 = bus floating), cycles owned, dead cycles left, next scan start.
  typedef struct { int own; int ten; int gap; int ptr; } mst_t;
  mst_t ms [4];

  function automatic mst_t step(input mst_t s, input logic [3:0] req, input int d, input int h);
    mst_t n;
    bit   found;
    n = s;
    if (s.own >= 0) begin
      if (!req[s.own] || (h != 0 && s.ten >= h)) begin
        n.own = -1;
        n.gap = d;
      end else n.ten = s.ten + 1;
    end else if (s.gap > 1) begin
      n.gap = s.gap - 1;
    end else begin
      n.gap = 0;
      found = 0;
      for (int j = 0; j < N; j++) begin
        int i;
        i = (s.ptr + j) % N;
        if (!found && req[i]) begin
          found = 1;
          n.own = i;
          n.ten = 1;
          n.ptr = (i + 1) % N;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_en(input mst_t s);
    return (s.own >= 0) ? 4'(1 << s.own) : 4'b0000;
  endfunction

  always @(posedge CLK or negedge RN) begin
    if (!RN) for (int k = 0; k < 4; k++) ms[k] <= '{-1, 0, 0, 0};
    else     for (int k = 0; k < 4; k++) ms[k] <= step(ms[k], REQ, DV[k], HV[k]);
  end

  always @(negedge CLK) begin
    for (int k = 0; k < 4; k++) begin
      chk("model_en",    k, 8'(en[k]),  8'(exp_en(ms[k])));
      chk("model_gnt",   k, 8'(gnt[k]), 8'(exp_en(ms[k])));
      chk("model_float", k, 8'(flt[k]), 8'(ms[k].own < 0));
      chk("model_owner", k, 8'(own[k]), 8'((ms[k].own >= 0) ? ms[k].own : 0));
      chk("onehot_en",   k, 8'($countones(en[k]) <= 1), 8'd1);
    end
  end

  // Called just after a negedge; reset pulse lands mid-cycle, clear of both edges.
  task automatic rst_pulse();
    REQ = 4'b0000;
    #2 RN = 1'b0;
    #2 RN = 1'b1;
    @(negedge CLK);
  endtask

  typedef struct { logic [3:0] req; logic [3:0] en; } vec_t;
  vec_t tbl [14];
  logic [3:0] seq [7];

  initial begin
    checks = 0;
    errors = 0;
    RN  = 1'b0;
    REQ = 4'b0000;
    tbl[0]  = '{4'b0001, 4'b0001};
    tbl[1]  = '{4'b0001, 4'b0001};
    tbl[2]  = '{4'b0001, 4'b0001};
    tbl[3]  = '{4'b0001, 4'b0001};
    tbl[4]  = '{4'b0001, 4'b0001};
    tbl[5]  = '{4'b0000, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0000};
    tbl[7]  = '{4'b0011, 4'b0010};
    tbl[8]  = '{4'b0011, 4'b0010};
    tbl[9]  = '{4'b0001, 4'b0000};
    tbl[10] = '{4'b0001, 4'b0001};
    tbl[11] = '{4'b0101, 4'b0001};
    tbl[12] = '{4'b0100, 4'b0000};
    tbl[13] = '{4'b0100, 4'b0100};

    repeat (2) @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      chk("rst_en",    k, 8'(en[k]),  8'h00);
      chk("rst_float", k, 8'(flt[k]), 8'h01);
      chk("rst_owner", k, 8'(own[k]), 8'h00);
    end
    RN = 1'b1;

    // Single request, release, pointer rotation, non-owner toggles ignored.
    for (int i = 0; i < 14; i++) begin
      REQ = tbl[i].req;
      @(negedge CLK);
      chk("tbl_en",    0, 8'(en[0]), 8'(tbl[i].en));
      chk("tbl_float", 0, 8'(flt[0]), 8'(tbl[i].en == 4'b0000));
    end

    // Contention handoff with two dead cycles.
    rst_pulse();
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
    REQ = 4'b0011;
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      chk("handoff_en", 1, 8'(en[1]), 8'(seq[c]));
      if (c == 2) REQ = 4'b0010;
    end

    // Async reset mid-ownership, then pointer must restart at 0.
    rst_pulse();
    REQ = 4'b0100;
    @(negedge CLK);
    chk("own2_en", 0, 8'(en[0]), 8'h04);
    #2 RN = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("async_en",    k, 8'(en[k]),  8'h00);
      chk("async_float", k, 8'(flt[k]), 8'h01);
      chk("async_owner", k, 8'(own[k]), 8'h00);
    end
    REQ = 4'b1001;
    #1 RN = 1'b1;
    @(negedge CLK);
    chk("ptr_restart_en", 0, 8'(en[0]), 8'h01);

    // Round-robin fairness under full load.
    rst_pulse();
    REQ = 4'b1111;
    repeat (40) @(negedge CLK);

    // Unlimited tenure never lets requester 2 in.
    rst_pulse();
    REQ = 4'b0101;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      chk("unlimited_en", 2, 8'(en[2]), 8'h01);
    end

    // Preempted owner re-wins after each dead gap.
    rst_pulse();
    REQ = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      chk("preempt_en", 3, 8'(en[3]), ((c % 5) < 2) ? 8'h01 : 8'h00);
    end

    // Random sticky requests with occasional resets.
    rst_pulse();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if ($urandom_range(199) == 0) rst_pulse();
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3) == 0) REQ[b] = ~REQ[b];
    end

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
